// File: rtl/nn_seq_pkg.sv
// Shared definitions for the NN unit-select sequencers: direction encoding,
// run FSM states and the one-place ring rotate helper.
package nn_seq_pkg;

    localparam logic DIR_RIGHT  = 1'b0;
    localparam logic DIR_LEFT   = 1'b1;

    // Widest ring any sequencer may instantiate; callers zero-extend into this.
    localparam int   RING_MAX_W = 64;

    typedef logic [RING_MAX_W-1:0] ring_word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    // Rotate the low 'width' bits of pattern by one place; bits above width come back zero.
    function automatic ring_word_t rotate(input ring_word_t pattern, input int width, input logic dir);
        ring_word_t mask;
        ring_word_t result;
        if (width >= RING_MAX_W) begin
            mask = '1;
        end else begin
            mask = (ring_word_t'(1'b1) << width) - ring_word_t'(1'b1);
        end
        if (dir == DIR_LEFT) begin
            result = ((pattern << 1) | (pattern >> (width - 1))) & mask;
        end else begin
            result = ((pattern >> 1) | (pattern << (width - 1))) & mask;
        end
        return result;
    endfunction

endpackage

// File: rtl/ring_sequencer_if.sv
// Control/status bundle between the NN controller (master) and a ring
// sequencer (slave).
interface ring_sequencer_if #(
    parameter int N      = 8,
    parameter int PASS_W = 8
);
    localparam int POS_W = (N > 1) ? $clog2(N) : 1;

    logic              start;
    logic [PASS_W-1:0] num_passes;
    logic              dir;
    logic              hold;
    logic              load_en;
    logic [N-1:0]      load_value;

    logic [N-1:0]      parallel_out;
    logic [POS_W-1:0]  position;
    logic              wrap;
    logic              busy;
    logic              done;

    modport master (
        output start, num_passes, dir, hold, load_en, load_value,
        input  parallel_out, position, wrap, busy, done
    );

    modport slave (
        input  start, num_passes, dir, hold, load_en, load_value,
        output parallel_out, position, wrap, busy, done
    );

endinterface

// File: rtl/ring_sequencer.sv
// Rotating N-bit unit-select ring: rotates a loaded pattern for a programmed
// number of full passes, with per-pass wrap and end-of-run done pulses.
module ring_sequencer
    import nn_seq_pkg::*;
#(
    parameter int           N             = 8,
    parameter logic [N-1:0] INITIAL_VALUE = N'(1'b1),
    parameter int           PASS_W        = 8
) (
    input  logic            clk,
    input  logic            reset,
    ring_sequencer_if.slave bus
);

    localparam int               POS_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N - 1);

    seq_state_e        state_r,    state_s;
    logic [N-1:0]      ring_r,     ring_s;
    logic [POS_W-1:0]  pos_r,      pos_s;
    logic [PASS_W-1:0] pass_cnt_r, pass_cnt_s;
    logic [PASS_W-1:0] passes_r,   passes_s;
    logic              dir_r,      dir_s;
    logic              busy_r,     busy_s;
    logic              wrap_r,     wrap_s;
    logic              done_r,     done_s;

    logic              pos_last_s;
    logic              pass_last_s;

    // End-of-pass and end-of-run detection on the current counters
    always_comb begin
        pos_last_s  = (pos_r == POS_LAST);
        pass_last_s = (pass_cnt_r == (passes_r - PASS_W'(1'b1)));
    end

    // Next-state and next-output logic for the IDLE/RUN controller
    always_comb begin
        state_s    = state_r;
        ring_s     = ring_r;
        pos_s      = pos_r;
        pass_cnt_s = pass_cnt_r;
        passes_s   = passes_r;
        dir_s      = dir_r;
        busy_s     = busy_r;
        wrap_s     = 1'b0;
        done_s     = 1'b0;

        case (state_r)
            IDLE: begin
                // A same-edge load lands first, so an accepted run rotates the loaded value.
                if (bus.load_en) begin
                    ring_s = bus.load_value;
                    pos_s  = '0;
                end else begin
                    ring_s = ring_r;
                end

                if (bus.start) begin
                    if (bus.num_passes != '0) begin
                        passes_s   = bus.num_passes;
                        dir_s      = bus.dir;
                        pos_s      = '0;
                        pass_cnt_s = '0;
                        busy_s     = 1'b1;
                        state_s    = RUN;
                    end else begin
                        done_s     = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            RUN: begin
                if (bus.hold) begin
                    ring_s = ring_r;
                end else begin
                    ring_s = N'(rotate(ring_word_t'(ring_r), N, dir_r));
                    if (pos_last_s) begin
                        pos_s  = '0;
                        wrap_s = 1'b1;
                        if (pass_last_s) begin
                            pass_cnt_s = '0;
                            done_s     = 1'b1;
                            busy_s     = 1'b0;
                            state_s    = IDLE;
                        end else begin
                            pass_cnt_s = pass_cnt_r + PASS_W'(1'b1);
                            state_s    = RUN;
                        end
                    end else begin
                        pos_s = pos_r + POS_W'(1'b1);
                    end
                end
            end

            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ring_r     <= INITIAL_VALUE;
            pos_r      <= '0;
            pass_cnt_r <= '0;
            passes_r   <= '0;
            dir_r      <= DIR_RIGHT;
            busy_r     <= 1'b0;
            wrap_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ring_r     <= ring_s;
            pos_r      <= pos_s;
            pass_cnt_r <= pass_cnt_s;
            passes_r   <= passes_s;
            dir_r      <= dir_s;
            busy_r     <= busy_s;
            wrap_r     <= wrap_s;
            done_r     <= done_s;
        end
    end

    assign bus.parallel_out = ring_r;
    assign bus.position     = pos_r;
    assign bus.wrap         = wrap_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;

endmodule

// File: tb/tb_ring_sequencer.sv
// Randomized plus directed bench for ring_sequencer (N=4), checked every cycle
// against a run-level model that derives outputs from the shift count.
module tb_ring_sequencer;
    import nn_seq_pkg::*;

    localparam int           N      = 4;
    localparam int           PASS_W = 8;
    localparam logic [N-1:0] INIT   = 4'b0001;
    localparam int           MASK   = (1 << N) - 1;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ring_sequencer_if #(.N(N), .PASS_W(PASS_W)) bus ();

    ring_sequencer #(.N(N), .INITIAL_VALUE(INIT), .PASS_W(PASS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int m_ring, m_base, m_pos, m_k, m_total;
    bit m_dir, m_busy, m_wrap, m_done;
    int busy_cnt, wrap_cnt, done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Start pattern rotated by k places in the given direction.
    function automatic int rot_ref(input int p, input bit d, input int k);
        int s;
        s = k % N;
        if (s == 0) return p;
        if (d == DIR_RIGHT) return ((p >> s) | (p << (N - s))) & MASK;
        return ((p << s) | (p >> (N - s))) & MASK;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        m_wrap = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_ring = int'(INIT);
            m_pos  = 0;
            m_busy = 1'b0;
            m_k    = 0;
        end else if (!m_busy) begin
            if (bus.load_en) begin
                m_ring = int'(bus.load_value);
                m_pos  = 0;
            end
            if (bus.start) begin
                if (bus.num_passes != 0) begin
                    m_base  = m_ring;
                    m_dir   = bus.dir;
                    m_total = N * int'(bus.num_passes);
                    m_k     = 0;
                    m_pos   = 0;
                    m_busy  = 1'b1;
                end else begin
                    m_done = 1'b1;
                end
            end
        end else if (!bus.hold) begin
            m_k++;
            m_ring = rot_ref(m_base, m_dir, m_k);
            m_pos  = m_k % N;
            m_wrap = (m_k % N == 0);
            if (m_k == m_total) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_eq("out",  bus.parallel_out, m_ring);
        check_eq("pos",  bus.position,     m_pos);
        check_eq("busy", bus.busy,         m_busy);
        check_eq("wrap", bus.wrap,         m_wrap);
        check_eq("done", bus.done,         m_done);
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.wrap === 1'b1) wrap_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.num_passes = 8'd0;
        bus.dir        = 1'b0;
        bus.hold       = 1'b0;
        bus.load_en    = 1'b0;
        bus.load_value = 4'b0000;
    endtask

    task automatic clear_counts();
        busy_cnt = 0;
        wrap_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_run(input int passes, input bit d);
        bus.start      = 1'b1;
        bus.num_passes = 8'(passes);
        bus.dir        = d;
        tick();
        idle_inputs();
    endtask

    logic [3:0] c1_exp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    logic [3:0] c2_exp [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};
    logic [3:0] c3_exp [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        int guard;
        reset = 1'b1;
        idle_inputs();
        clear_counts();
        tick();
        tick();
        check_eq("rst_out",  bus.parallel_out, 4'b0001);
        check_eq("rst_pos",  bus.position, 2'd0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_wrap", bus.wrap, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        reset = 1'b0;
        tick();

        // One right-rotating pass.
        clear_counts();
        start_run(1, DIR_RIGHT);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("c1_seq", bus.parallel_out, c1_exp[i]);
        end
        check_eq("c1_busy_cycles", busy_cnt, 4);
        check_eq("c1_wraps", wrap_cnt, 1);
        check_eq("c1_dones", done_cnt, 1);

        // Load 0011 then two left-rotating passes.
        bus.load_en    = 1'b1;
        bus.load_value = 4'b0011;
        tick();
        idle_inputs();
        clear_counts();
        start_run(2, DIR_LEFT);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("c2_seq", bus.parallel_out, c2_exp[i % 4]);
        end
        check_eq("c2_busy_cycles", busy_cnt, 8);
        check_eq("c2_wraps", wrap_cnt, 2);
        check_eq("c2_dones", done_cnt, 1);

        // Hold stalls the 2nd and 3rd run cycles.
        bus.load_en    = 1'b1;
        bus.load_value = 4'b0001;
        tick();
        idle_inputs();
        clear_counts();
        start_run(1, DIR_RIGHT);
        for (int i = 0; i < 6; i++) begin
            bus.hold = (i == 1 || i == 2);
            tick();
            check_eq("c3_seq", bus.parallel_out, c3_exp[i]);
        end
        bus.hold = 1'b0;
        check_eq("c3_busy_cycles", busy_cnt, 6);
        check_eq("c3_wraps", wrap_cnt, 1);
        check_eq("c3_dones", done_cnt, 1);

        // Zero passes: immediate done, no busy.
        clear_counts();
        start_run(0, DIR_RIGHT);
        check_eq("c4_done", bus.done, 1'b1);
        tick();
        check_eq("c4_busy_cycles", busy_cnt, 0);
        check_eq("c4_out", bus.parallel_out, 4'b0001);

        // Start/load ignored while busy, then reset mid-run.
        clear_counts();
        start_run(1, DIR_RIGHT);
        tick();
        bus.start      = 1'b1;
        bus.load_en    = 1'b1;
        bus.load_value = 4'b1111;
        tick();
        check_eq("c5_ignored", bus.parallel_out, 4'b0100);
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("c5_rst_out", bus.parallel_out, 4'b0001);
        check_eq("c5_rst_busy", bus.busy, 1'b0);
        tick();
        tick();
        check_eq("c5_wraps", wrap_cnt, 0);
        check_eq("c5_dones", done_cnt, 0);

        // Randomized runs with noise on ignored inputs and rare resets.
        for (int r = 0; r < 40; r++) begin
            bus.load_en    = 1'($urandom);
            bus.load_value = 4'($urandom);
            start_run($urandom_range(0, 3), 1'($urandom));
            guard = 0;
            while (m_busy && guard < 100) begin
                bus.hold       = ($urandom_range(0, 3) == 0);
                bus.start      = 1'($urandom);
                bus.load_en    = 1'($urandom);
                bus.load_value = 4'($urandom);
                bus.dir        = 1'($urandom);
                bus.num_passes = 8'($urandom);
                reset          = ($urandom_range(0, 59) == 0);
                tick();
                guard++;
            end
            reset = 1'b0;
            idle_inputs();
            check_eq("rand_run_bounded", 32'(guard < 100), 32'd1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
